// File: rtl/simple_rx_checker.sv
// Stream receive checker: validates fixed-pattern packets and keeps
// clean/error packet and byte statistics.
module simple_rx_checker #(
    parameter int C_S_AXIS_DATA_WIDTH  = 64,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_CHECK_PKT_SIZE     = 2,
    parameter logic [C_S_AXIS_TUSER_WIDTH-1:0] C_EXP_TUSER     = 128'h04800040,
    parameter logic [C_S_AXIS_DATA_WIDTH-1:0]  C_EXP_HDR_WORD  = 64'haaaaaaaaaaaaaaaa,
    parameter logic [C_S_AXIS_DATA_WIDTH-1:0]  C_EXP_DATA_WORD = 64'hffffffffffffffff
) (
    input  logic                              axi_aclk,
    input  logic                              axi_aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic                              rx_enable,
    input  logic                              rst_cntrs,
    output logic [31:0]                       rx_count,
    output logic [31:0]                       err_count,
    output logic [31:0]                       byte_count,
    output logic                              pkt_done,
    output logic                              pkt_err
);

    localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam logic [15:0] LAST_IDX = 16'(C_CHECK_PKT_SIZE - 1);

    typedef enum logic {
        WAIT_SOP,
        IN_PKT
    } state_t;

    state_t      state;
    logic [15:0] beat_idx;
    logic        err_flag;
    logic        accept;
    logic        beat_err;
    logic        pkt_bad;
    logic        pkt_end;
    logic [31:0] strb_pop;

    assign accept  = s_axis_tvalid & s_axis_tready;
    assign pkt_end = accept & s_axis_tlast;
    assign pkt_bad = err_flag | beat_err;

    // Per-beat error: content, byte qualifiers and length position.
    always_comb begin
        beat_err = 1'b0;
        if (state == WAIT_SOP) begin
            if (s_axis_tdata != C_EXP_HDR_WORD) beat_err = 1'b1;
            if (s_axis_tuser != C_EXP_TUSER)    beat_err = 1'b1;
        end else begin
            if (s_axis_tdata != C_EXP_DATA_WORD) beat_err = 1'b1;
        end
        if (!(&s_axis_tstrb)) beat_err = 1'b1;
        if (s_axis_tlast && (beat_idx != LAST_IDX)) beat_err = 1'b1;
    end

    // Number of qualified bytes in the current beat.
    always_comb begin
        strb_pop = '0;
        for (int i = 0; i < STRB_W; i++) begin
            strb_pop = strb_pop + 32'(s_axis_tstrb[i]);
        end
    end

    // Ready follows rx_enable one cycle late so disabling only stalls.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            s_axis_tready <= 1'b0;
        end else begin
            s_axis_tready <= rx_enable;
        end
    end

    // Packet framing FSM with beat index and sticky error flag.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state    <= WAIT_SOP;
            beat_idx <= '0;
            err_flag <= 1'b0;
            pkt_done <= 1'b0;
            pkt_err  <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            pkt_err  <= 1'b0;
            if (accept) begin
                if (s_axis_tlast) begin
                    state    <= WAIT_SOP;
                    beat_idx <= '0;
                    err_flag <= 1'b0;
                    pkt_done <= 1'b1;
                    pkt_err  <= pkt_bad;
                end else begin
                    state    <= IN_PKT;
                    err_flag <= pkt_bad;
                    if (beat_idx != 16'hffff) begin
                        beat_idx <= beat_idx + 16'd1;
                    end
                end
            end
        end
    end

    // Statistics counters; clear request wins over same-cycle updates.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn || rst_cntrs) begin
            rx_count   <= '0;
            err_count  <= '0;
            byte_count <= '0;
        end else begin
            if (accept) begin
                byte_count <= byte_count + strb_pop;
            end
            if (pkt_end && !pkt_bad) begin
                rx_count <= rx_count + 32'd1;
            end
            if (pkt_end && pkt_bad) begin
                err_count <= err_count + 32'd1;
            end
        end
    end

endmodule

// File: doc/simple_rx_checker.md
SIMPLE_RX_CHECKER -- requirements
Module: simple_rx_checker

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 64, slave stream data width.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, slave stream tuser width.
REQ-003 SHALL have parameter C_CHECK_PKT_SIZE, default 2, expected packet length in beats (range 1..65535).
REQ-004 SHALL have parameter C_EXP_TUSER, default 128'h04800040, expected tuser on first beat.
REQ-005 SHALL have parameter C_EXP_HDR_WORD, default 64'haaaaaaaaaaaaaaaa, expected tdata on first beat.
REQ-006 SHALL have parameter C_EXP_DATA_WORD, default 64'hffffffffffffffff, expected tdata on every later beat.
REQ-007 SHALL have ports:
- axi_aclk  in  1  sole clock, all logic on rising edge
- axi_aresetn  in  1  reset, synchronous, active-low
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  stream data
- s_axis_tstrb  in  C_S_AXIS_DATA_WIDTH/8  byte qualifiers
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  sideband; checked on first beat only
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accept, registered
- s_axis_tlast  in  1  last beat of packet
- rx_enable  in  1  gate; 1 = accept traffic
- rst_cntrs  in  1  synchronous clear of statistics counters
- rx_count  out  32  packets received without error
- err_count  out  32  packets received with >=1 error
- byte_count  out  32  total valid bytes accepted
- pkt_done  out  1  one-cycle pulse, packet completed
- pkt_err  out  1  one-cycle pulse with pkt_done when packet had errors

Function
REQ-008 A beat SHALL be accepted only in a cycle where s_axis_tvalid and s_axis_tready are both 1; no other cycle changes checker state.
REQ-009 s_axis_tready SHALL equal rx_enable delayed by one cycle; deasserting rx_enable mid-packet SHALL stall, not abort, the packet.
REQ-010 FSM SHALL have states WAIT_SOP and IN_PKT; reset state WAIT_SOP.
REQ-011 WAIT_SOP: accepted beat with tlast=0 -> IN_PKT; accepted beat with tlast=1 -> completes a 1-beat packet, stays WAIT_SOP.
REQ-012 IN_PKT: accepted beat with tlast=1 -> WAIT_SOP, packet complete; otherwise stays IN_PKT.
REQ-013 Beat index SHALL count accepted beats within a packet from 0, 16 bits, saturating at 65535.
REQ-014 Beat 0 SHALL be flagged error if tdata != C_EXP_HDR_WORD or tuser != C_EXP_TUSER.
REQ-015 Beats >=1 SHALL be flagged error if tdata != C_EXP_DATA_WORD; tuser ignored.
REQ-016 Any beat SHALL be flagged error if tstrb is not all ones.
REQ-017 Length error SHALL be flagged if tlast arrives at beat index != C_CHECK_PKT_SIZE-1 (short or long packet); long packets are consumed until tlast.
REQ-018 Per-packet error flag SHALL be sticky from first flagged beat to packet completion, including errors on the tlast beat itself.
REQ-019 On completion cycle +1: pkt_done=1 for one cycle; pkt_err=1 iff packet errored; rx_count+1 if clean else err_count+1; exactly one counter increments per packet.
REQ-020 byte_count SHALL add popcount(tstrb) for every accepted beat, one cycle after acceptance.
REQ-021 All counters SHALL wrap modulo 2^32 without saturation.
REQ-022 rst_cntrs=1 SHALL clear rx_count, err_count, byte_count next cycle and override any simultaneous increment; it SHALL NOT affect FSM, beat index, or per-packet error flag.
REQ-023 Back-to-back packets (tlast followed by next beat in the very next cycle) SHALL be checked with zero idle cycles required.

Reset
REQ-024 While axi_aresetn=0 at a clock edge: state=WAIT_SOP, beat index=0, error flag=0, s_axis_tready=0, pkt_done=0, pkt_err=0, rx_count=err_count=byte_count=0.
REQ-025 Reset mid-packet SHALL discard the partial packet with no counter increment; first accepted beat after reset is treated as beat 0.

Verification
REQ-026 Scenario: rx_enable=1, send 3 back-to-back 2-beat packets {aaaa..., tuser 04800040, tstrb ff}, {ffff..., tlast} -> rx_count=3, err_count=0, byte_count=48, three pkt_done pulses, pkt_err never 1.
REQ-027 Scenario: one packet with beat 1 tdata=64'h0 -> err_count=1, rx_count=0, pkt_err pulses with pkt_done.
REQ-028 Scenario: 1-beat packet (tlast on beat 0) then 3-beat packet -> err_count=2, byte_count=32, FSM returns WAIT_SOP after each.
REQ-029 Scenario: rx_enable low for 5 cycles between beat 0 and beat 1 with tvalid held -> s_axis_tready low for those cycles, packet still counted clean, rx_count=1.
REQ-030 Scenario: rst_cntrs pulsed in the same cycle a packet's count would increment, with rx_count=7 -> rx_count=0 afterward; next clean packet gives rx_count=1.
REQ-031 Scenario: axi_aresetn low for 2 cycles after beat 0 of a packet, then a clean 2-beat packet -> rx_count=1, err_count=0.
